// File: rtl/pico_stim_driver_if.sv
// Switch/LED bus to the picoMIPS core plus the expected-value ROM port.
// The master drives the operand and strobe; the slave returns result and ROM data.
interface pico_stim_if;
  logic [7:0] sw_data;
  logic       sw_strobe;
  logic [7:0] dut_result;
  logic [7:0] exp_addr;
  logic [7:0] exp_data;

  modport master (output sw_data, sw_strobe, exp_addr, input dut_result, exp_data);
  modport slave  (input sw_data, sw_strobe, exp_addr, output dut_result, exp_data);
endinterface

// File: rtl/pico_stim_driver.sv
// On-board stimulus sequencer: steps an operand 0..LAST_VALUE through the core,
// compares each LED result with a ROM expectation, and keeps error statistics.
module pico_stim_driver #(
  parameter int SETUP_CYCLES  = 10,
  parameter int STROBE_CYCLES = 30,
  parameter int SETTLE_CYCLES = 5,
  parameter int LAST_VALUE    = 254
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  pico_stim_if.master io,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_count,
  output logic [7:0]  first_err_addr
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_load;
  logic [7:0]      operand;
  logic            strobe_q;
  logic            start_run;
  logic            is_last;
  logic            mismatch;

  assign start_run = start && (state == ST_IDLE || state == ST_DONE);
  assign is_last   = (operand == 8'(LAST_VALUE));
  assign mismatch  = (io.dut_result != io.exp_data);

  assign io.sw_data   = operand;
  assign io.exp_addr  = operand;
  assign io.sw_strobe = strobe_q;

  // One shared down-counter; each timed state loads its own length on entry.
  always_comb begin
    cnt_load = '0;
    case (state_nxt)
      ST_SETUP:  cnt_load = CW'(SETUP_CYCLES - 1);
      ST_STROBE: cnt_load = CW'(STROBE_CYCLES - 1);
      ST_SETTLE: cnt_load = CW'(SETTLE_CYCLES - 1);
      default:   cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      operand        <= '0;
      strobe_q       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state    <= state_nxt;
      // Strobe is a flop fed from the next state, so it never glitches.
      strobe_q <= (state_nxt == ST_STROBE);
      if (state_nxt != state)
        cnt <= cnt_load;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;

      if (start_run) begin
        operand        <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (state == ST_CHECK) begin
        if (mismatch) begin
          if (err_count != 9'h1FF) err_count <= err_count + 9'd1;
          if (err_count == 9'd0)   first_err_addr <= operand;
        end
        // Hold on the last operand so LAST_VALUE=255 never wraps.
        if (!is_last) operand <= operand + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETUP;
      ST_SETUP:         if (cnt == '0) state_nxt = ST_STROBE;
      ST_STROBE:        if (cnt == '0) state_nxt = ST_SETTLE;
      ST_SETTLE:        if (cnt == '0) state_nxt = ST_CHECK;
      ST_CHECK:         state_nxt = is_last ? ST_DONE : ST_SETUP;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      ST_SETUP, ST_STROBE, ST_SETTLE, ST_CHECK: busy = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        pass = (err_count == 9'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pico_stim_driver.sv
// Directed bench: reset behaviour, ideal/faulty/stuck runs on LAST_VALUE=254,
// and a full 256-operand run on a LAST_VALUE=255 instance.
module tb_pico_stim_driver;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [8:0] err_a, err_b;
  logic [7:0] ferr_a, ferr_b;
  int mode = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  pico_stim_if ifa ();
  pico_stim_if ifb ();

  pico_stim_driver dut_a (
    .clk(clk), .n_reset(n_reset), .start(start_a), .io(ifa),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_addr(ferr_a)
  );

  pico_stim_driver #(.LAST_VALUE(255)) dut_b (
    .clk(clk), .n_reset(n_reset), .start(start_b), .io(ifb),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_addr(ferr_b)
  );

  // Registered ROM models; mode 2 is the stuck-result scenario.
  always @(posedge clk)
    ifa.exp_data <= (mode == 2) ? 8'(ifa.exp_addr + 8'd1) : (ifa.exp_addr ^ 8'h5A);
  always @(posedge clk)
    ifb.exp_data <= ifb.exp_addr ^ 8'hA5;

  assign ifa.dut_result = (mode == 2) ? 8'h00 :
                          (mode == 1 && (ifa.sw_data == 8'd7 || ifa.sw_data == 8'd200)) ?
                          (ifa.exp_data ^ 8'h01) : ifa.exp_data;
  assign ifb.dut_result = ifb.exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Waveform monitor for strobe width, setup length, leakage and operand order.
  logic       mon_en = 1'b0;
  logic       prev_s = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_d = 8'd0;
  int low_run = 0, hi_run = 0, n_strobe = 0;
  int setup_bad = 0, hi_bad = 0, leak_bad = 0, seq_bad = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_a && prev_busy && ifa.sw_data != prev_d && ifa.sw_data != 8'(prev_d + 8'd1))
        seq_bad++;
      if ((busy_a && !prev_busy) || ifa.sw_data != prev_d) low_run = 1;
      else if (!ifa.sw_strobe) low_run++;
      if (ifa.sw_strobe && !prev_s) begin
        if (low_run != 10) setup_bad++;
        hi_run = 1;
        n_strobe++;
      end else if (ifa.sw_strobe) hi_run++;
      if (!ifa.sw_strobe && prev_s && hi_run != 30) hi_bad++;
      if (ifa.sw_strobe && !busy_a) leak_bad++;
    end
    prev_s    = ifa.sw_strobe;
    prev_busy = busy_a;
    prev_d    = ifa.sw_data;
  end

  task automatic clr_mon();
    n_strobe = 0; setup_bad = 0; hi_bad = 0; leak_bad = 0; seq_bad = 0;
  endtask

  // Start a run on dut_a; optionally re-pulse start at cycle pulse_at while busy.
  task automatic run_a(input int pulse_at, output int cycles);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    chk("busy_rise", busy_a, 1);
    chk("err_clr", err_a, 0);
    chk("ferr_clr", ferr_a, 0);
    chk("op_start", ifa.sw_data, 0);
    cycles = 0;
    while (!done_a && cycles < 20000) begin
      start_a = (cycles == pulse_at);
      @(negedge clk);
      cycles++;
    end
    start_a = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_sw_data", ifa.sw_data, 0);
    chk("rst_strobe", ifa.sw_strobe, 0);
    chk("rst_exp_addr", ifa.exp_addr, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ferr", ferr_a, 0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted 20 cycles into a run lands mid-strobe.
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_strobe", ifa.sw_strobe, 1);
    n_reset = 1'b0;
    #1;
    chk("async_strobe", ifa.sw_strobe, 0);
    chk("async_busy", busy_a, 0);
    chk("async_sw_data", ifa.sw_data, 0);
    @(negedge clk); n_reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_done", done_a, 0);
    chk("idle_strobe", ifa.sw_strobe, 0);

    // Ideal core.
    mode = 0; clr_mon(); mon_en = 1'b1;
    run_a(-1, cyc);
    chk("ideal_cycles", cyc, 11730);
    chk("ideal_done", done_a, 1);
    chk("ideal_busy", busy_a, 0);
    chk("ideal_pass", pass_a, 1);
    chk("ideal_err", err_a, 0);
    chk("ideal_ferr", ferr_a, 0);
    chk("ideal_last_op", ifa.sw_data, 254);
    chk("ideal_n_strobe", n_strobe, 255);
    chk("ideal_setup_bad", setup_bad, 0);
    chk("ideal_hi_bad", hi_bad, 0);
    chk("ideal_leak_bad", leak_bad, 0);

    // Faults at 7 and 200, started from DONE, with a stray start mid-run.
    mode = 1; clr_mon();
    run_a(3000, cyc);
    chk("fault_cycles", cyc, 11730);
    chk("fault_err", err_a, 2);
    chk("fault_ferr", ferr_a, 7);
    chk("fault_pass", pass_a, 0);
    chk("fault_done", done_a, 1);
    chk("fault_seq_bad", seq_bad, 0);
    chk("fault_n_strobe", n_strobe, 255);

    // Stuck result: every operand mismatches; replay clears previous stats.
    mode = 2; clr_mon();
    run_a(-1, cyc);
    chk("stuck_err", err_a, 255);
    chk("stuck_ferr", ferr_a, 0);
    chk("stuck_pass", pass_a, 0);
    mon_en = 1'b0;

    // LAST_VALUE=255: 256 operands, no wrap.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    chk("b_busy_rise", busy_b, 1);
    cyc = 0;
    while (!done_b && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_cycles", cyc, 11776);
    chk("b_last_op", ifb.sw_data, 255);
    chk("b_err", err_b, 0);
    chk("b_pass", pass_b, 1);
    repeat (3) @(negedge clk);
    chk("b_hold_op", ifb.sw_data, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pico_stim_driver.md
# pico_stim_driver

Synthesisable on-board stimulus sequencer that drives the picoMIPS switch interface and checks its LED result. It steps an 8-bit operand through 0..LAST_VALUE. For each operand it presents the operand, pulses the load strobe, waits for the result to settle, and compares the LED byte against an expected value read from a lookup ROM. It sits beside the picoMIPS core on the FPGA top level. It replaces the manual switch/observe loop with a self-checking run and exposes a pass flag and error statistics.

## Interface
Parameters:
- SETUP_CYCLES, 10, cycles `sw_data` is stable with strobe low before the strobe rises (min 1)
- STROBE_CYCLES, 30, cycles strobe is held high (min 1)
- SETTLE_CYCLES, 5, cycles after strobe falls before the result is sampled (min 1)
- LAST_VALUE, 254, final operand (0..255)

Ports:
- clk  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled high for one cycle in IDLE or DONE
- sw_data  out  8  operand to core (drives SW[7:0])
- sw_strobe  out  1  load strobe to core (drives SW[8])
- dut_result  in  8  core LED output
- exp_addr  out  8  expected-value ROM address, equals current operand
- exp_data  in  8  ROM data, valid 1 cycle after exp_addr changes
- busy  out  1  high from start acceptance until DONE
- done  out  1  high in DONE
- pass  out  1  high in DONE when err_count == 0
- err_count  out  9  number of mismatching operands in the current run
- first_err_addr  out  8  operand of the first mismatch; 0 if none

## Operation
- States: IDLE, SETUP, STROBE, SETTLE, CHECK, DONE.
- IDLE: outputs are at reset values. On start=1, go to SETUP:
  - operand := 0
  - clear err_count and first_err_addr
  - busy := 1
- SETUP: sw_strobe=0. Hold SETUP_CYCLES cycles, then go to STROBE.
- STROBE: sw_strobe=1 for STROBE_CYCLES cycles, then go to SETTLE.
- SETTLE: sw_strobe=0 for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle): compare dut_result with exp_data.
  - On mismatch, increment err_count, saturating at 511.
  - On the first mismatch (err_count was 0), load first_err_addr := operand.
  - If operand == LAST_VALUE, go to DONE. Otherwise operand += 1 and go to SETUP.
- DONE: busy=0, done=1, pass=(err_count==0).
  - err_count and first_err_addr hold their values.
  - start=1 begins a new run exactly as from IDLE.
- sw_data and exp_addr always equal operand. They change only on the CHECK→SETUP transition or on run start.
- start while busy is ignored.
- A single cycle counter is shared by SETUP/STROBE/SETTLE. It reloads on every state entry.
- Comparison is unsigned, bitwise equality on 8 bits.

## Timing
- Reset values:
  - state IDLE, sw_data 0, sw_strobe 0, exp_addr 0
  - busy 0, done 0, pass 0, err_count 0, first_err_addr 0
- Reset is asynchronous. Assertion mid-run returns to IDLE immediately, strobe low. The run is not resumed.
- busy rises on the clock edge after start is sampled high.
- Per operand: SETUP_CYCLES + STROBE_CYCLES + SETTLE_CYCLES + 1 cycles. Defaults give 46 cycles.
- Full run: (LAST_VALUE+1) × 46 cycles. Defaults give 11730 cycles from busy rising to done rising.
- exp_data is registered and arrives 1 cycle after exp_addr. Because SETUP_CYCLES ≥ 1, it is always valid by CHECK.
- sw_strobe is registered and glitch-free. It is never high in IDLE, DONE or CHECK.
- If LAST_VALUE = 0, exactly one operand is run.
- If LAST_VALUE = 255, the operand must not wrap: the run ends after operand 255.

## Test plan
- Reset mid-STROBE (assert n_reset at cycle 20 of run):
  - sw_strobe drops asynchronously, all outputs take reset values.
  - After release, the block stays in IDLE until start.
- Ideal model (dut_result follows exp_data), default parameters:
  - done rises 11730 cycles after busy.
  - pass=1, err_count=0, first_err_addr=0.
  - Each strobe is exactly 30 cycles high with 10 setup cycles before it.
- Faults injected at operands 7 and 200:
  - err_count=2, first_err_addr=7, pass=0.
- Stuck result (dut_result fixed at 0x00, exp_data=operand+1):
  - err_count=255, first_err_addr=0.
- Sequencing of start:
  - start pulsed during busy is ignored; operand sequence is unaffected.
  - start in DONE clears err_count and replays from operand 0.
- LAST_VALUE=255:
  - 256 operands are checked; sw_data ends at 255 and does not wrap to 0.
  - done is asserted after 11776 cycles.
